// File: rtl/dino_pkg.sv
// Shared types and jump-trajectory constants for the two-lane dinosaur runner.
package dino_pkg;

  typedef enum logic [1:0] {LANE_GROUND, LANE_RISE, LANE_FALL, LANE_DEAD} lane_state_t;
  typedef enum logic [1:0] {GAME_WAIT, GAME_RUN, GAME_OVER} game_state_t;

  localparam int JUMP_STEPS = 64;
  localparam int STEP_W     = 6;

  localparam int PH_FAST_END  = 10;
  localparam int PH_MID_END   = 20;
  localparam int PH_PEAK      = 32;
  localparam int PH_FALL_SLOW = 44;
  localparam int PH_FALL_MID  = 54;

  localparam int D_FAST = 6;
  localparam int D_MID  = 4;
  localparam int D_SLOW = 2;

  // Magnitude of the Y move for the tick taken at this step; direction comes from the phase.
  function automatic logic [2:0] step_delta(input logic [STEP_W-1:0] step);
    if (step < STEP_W'(PH_FAST_END))       return 3'(D_FAST);
    else if (step < STEP_W'(PH_MID_END))   return 3'(D_MID);
    else if (step < STEP_W'(PH_FALL_SLOW)) return 3'(D_SLOW);
    else if (step < STEP_W'(PH_FALL_MID))  return 3'(D_MID);
    else                                   return 3'(D_FAST);
  endfunction

endpackage

// File: rtl/dino_jump_lane.sv
// One lane: GROUND/RISE/FALL/DEAD sequencer with step counter, one-deep jump buffer and Y register.
module dino_jump_lane
  import dino_pkg::*;
#(
  parameter int Y_W      = 9,
  parameter int GROUND_Y = 146,
  parameter int BUF_WIN  = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           restart,
  input  logic           accept_en,
  input  logic           run_en,
  input  logic           tick,
  input  logic           jump_req,
  input  logic           hit,
  output logic [Y_W-1:0] y,
  output lane_state_t    state_dbg
);

  localparam logic [Y_W-1:0]    Y_GND     = Y_W'(GROUND_Y);
  localparam logic [STEP_W-1:0] BUF_START = STEP_W'(JUMP_STEPS - BUF_WIN);
  localparam logic [STEP_W-1:0] TOP_STEP  = STEP_W'(PH_PEAK - 1);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(JUMP_STEPS - 1);
  localparam logic [STEP_W-1:0] RISE_END  = STEP_W'(PH_PEAK);

  lane_state_t       state, state_n;
  logic [STEP_W-1:0] step, step_n;
  logic              pending, pending_n;
  logic [Y_W-1:0]    y_n;
  logic [Y_W-1:0]    delta;
  logic              in_window;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= LANE_GROUND;
      step    <= '0;
      pending <= 1'b0;
      y       <= Y_GND;
    end else begin
      state   <= state_n;
      step    <= step_n;
      pending <= pending_n;
      y       <= y_n;
    end
  end

  always_comb begin
    state_n   = state;
    step_n    = step;
    pending_n = pending;
    y_n       = y;
    delta     = Y_W'(step_delta(step));
    in_window = (state == LANE_FALL) && (step >= BUF_START);
    if (restart) begin
      state_n   = LANE_GROUND;
      step_n    = '0;
      pending_n = 1'b0;
      y_n       = Y_GND;
    end else if (state != LANE_DEAD) begin
      if (run_en && hit) begin
        // Y and step freeze where they are; any coincident tick is dropped.
        state_n   = LANE_DEAD;
        pending_n = 1'b0;
      end else if (state == LANE_GROUND) begin
        if (accept_en && jump_req) begin
          state_n   = LANE_RISE;
          step_n    = '0;
          pending_n = 1'b0;
        end
      end else if (run_en) begin
        pending_n = pending | (jump_req && in_window);
        if (tick) begin
          step_n = step + STEP_W'(1);
          y_n    = (step < RISE_END) ? (y - delta) : (y + delta);
          if (step == TOP_STEP) state_n = LANE_FALL;
          if (step == LAST_STEP) begin
            // Landing tick: a buffered request chains straight into a new rise.
            state_n   = pending_n ? LANE_RISE : LANE_GROUND;
            pending_n = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    state_dbg = state;
  end

endmodule

// File: rtl/dino_lane_sequencer.sv
// Game-flow controller: WAIT/RUN/OVER FSM, walking-leg timer and two jump lanes.
module dino_lane_sequencer
  import dino_pkg::*;
#(
  parameter int GROUND_Y0 = 146,
  parameter int GROUND_Y1 = 386,
  parameter int Y_W       = 9,
  parameter int LEG_TICKS = 16,
  parameter int BUF_WIN   = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           tick,
  input  logic [1:0]     jump_req,
  input  logic [1:0]     hit,
  input  logic           restart,
  output logic [Y_W-1:0] dino_y0,
  output logic [Y_W-1:0] dino_y1,
  output logic [1:0]     jumping,
  output logic [1:0]     crash,
  output logic           leg,
  output logic           running,
  output logic           game_over
);

  localparam int LEG_W = (LEG_TICKS > 1) ? $clog2(LEG_TICKS) : 1;

  game_state_t    gs, gs_n;
  lane_state_t    lane0_st, lane1_st;
  logic           run_en, accept_en;
  logic [LEG_W-1:0] leg_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) gs <= GAME_WAIT;
    else     gs <= gs_n;
  end

  always_comb begin
    gs_n = gs;
    if (restart) begin
      gs_n = GAME_WAIT;
    end else begin
      case (gs)
        GAME_WAIT: if (|jump_req) gs_n = GAME_RUN;
        GAME_RUN:  if (crash == 2'b11) gs_n = GAME_OVER;
        default:   gs_n = gs;
      endcase
    end
  end

  always_comb begin
    run_en     = (gs == GAME_RUN);
    accept_en  = (gs != GAME_OVER);
    running    = (gs == GAME_RUN);
    game_over  = (gs == GAME_OVER);
    jumping[0] = (lane0_st == LANE_RISE) || (lane0_st == LANE_FALL);
    jumping[1] = (lane1_st == LANE_RISE) || (lane1_st == LANE_FALL);
    crash[0]   = (lane0_st == LANE_DEAD);
    crash[1]   = (lane1_st == LANE_DEAD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      leg_cnt <= '0;
      leg     <= 1'b0;
    end else if (restart) begin
      leg_cnt <= '0;
      leg     <= 1'b0;
    end else if (run_en && tick) begin
      if (leg_cnt == LEG_W'(LEG_TICKS - 1)) begin
        leg_cnt <= '0;
        leg     <= ~leg;
      end else begin
        leg_cnt <= leg_cnt + LEG_W'(1);
      end
    end
  end

  dino_jump_lane #(.Y_W(Y_W), .GROUND_Y(GROUND_Y0), .BUF_WIN(BUF_WIN)) u_lane0 (
    .clk      (clk),
    .rst      (rst),
    .restart  (restart),
    .accept_en(accept_en),
    .run_en   (run_en),
    .tick     (tick),
    .jump_req (jump_req[0]),
    .hit      (hit[0]),
    .y        (dino_y0),
    .state_dbg(lane0_st)
  );

  dino_jump_lane #(.Y_W(Y_W), .GROUND_Y(GROUND_Y1), .BUF_WIN(BUF_WIN)) u_lane1 (
    .clk      (clk),
    .rst      (rst),
    .restart  (restart),
    .accept_en(accept_en),
    .run_en   (run_en),
    .tick     (tick),
    .jump_req (jump_req[1]),
    .hit      (hit[1]),
    .y        (dino_y1),
    .state_dbg(lane1_st)
  );

endmodule
